// File: rtl/rx_sync_fifo.sv
// Single-clock receive FIFO between the UART receiver and the host read port.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read port.
module rx_sync_fifo #(
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                               Clk,
    input  logic                               Rst,
    input  logic                               Wr_En,
    input  logic [DATA_BITS-1:0]               Wr_Data,
    input  logic                               BIST_Mode,
    input  logic                               Rd_En,
    output logic [DATA_BITS-1:0]               Rd_Data,
    output logic                               Rd_Valid,
    input  logic                               Clr_Err,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    Count,
    output logic                               Empty,
    output logic                               Full,
    output logic                               Almost_Full,
    output logic                               Overflow,
    output logic                               Underflow
);

    localparam int PTR_BITS = $clog2(FIFO_DEPTH);
    localparam int CNT_BITS = $clog2(FIFO_DEPTH + 1);

    logic [DATA_BITS-1:0] mem [0:FIFO_DEPTH-1];
    logic [PTR_BITS-1:0]  wr_ptr;
    logic [PTR_BITS-1:0]  rd_ptr;
    logic [CNT_BITS-1:0]  next_count;
    logic                 wr_ok;
    logic                 rd_ok;
    logic                 ovf_event;
    logic                 udf_event;

    // A full FIFO still accepts a write when the same cycle pops an entry.
    assign rd_ok     = Rd_En & ~Empty;
    assign wr_ok     = Wr_En & ~BIST_Mode & (~Full | rd_ok);
    assign ovf_event = Wr_En & ~BIST_Mode & Full & ~rd_ok;
    assign udf_event = Rd_En & Empty;

    always_comb begin
        next_count = Count;
        if (wr_ok && !rd_ok) begin
            next_count = Count + CNT_BITS'(1);
        end else if (rd_ok && !wr_ok) begin
            next_count = Count - CNT_BITS'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst && wr_ok) begin
            mem[wr_ptr] <= Wr_Data;
        end
    end

    // Status flags are registered from next_count so they always agree with Count.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            Count       <= '0;
            Empty       <= 1'b1;
            Full        <= 1'b0;
            Almost_Full <= 1'b0;
            Overflow    <= 1'b0;
            Underflow   <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_BITS'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_BITS'(1);
            end
            Count       <= next_count;
            Empty       <= (next_count == '0);
            Full        <= (next_count == CNT_BITS'(FIFO_DEPTH));
            Almost_Full <= (next_count >= CNT_BITS'(AFULL_LEVEL));
            if (ovf_event) begin
                Overflow <= 1'b1;
            end else if (Clr_Err) begin
                Overflow <= 1'b0;
            end
            if (udf_event) begin
                Underflow <= 1'b1;
            end else if (Clr_Err) begin
                Underflow <= 1'b0;
            end
        end
    end

`ifdef FIFO_FWFT_EN
    assign Rd_Data  = Empty ? '0 : mem[rd_ptr];
    assign Rd_Valid = ~Empty;
`else
    logic [DATA_BITS-1:0] rd_data_q;
    logic                 rd_valid_q;

    // The head is sampled before any same-edge write, so a full-FIFO read+write returns the old head.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_ok;
            if (rd_ok) begin
                rd_data_q <= mem[rd_ptr];
            end
        end
    end

    assign Rd_Data  = rd_data_q;
    assign Rd_Valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_rx_sync_fifo.sv
// Randomised self-checking bench for rx_sync_fifo against a queue-based reference model.
// Follows FIFO_FWFT_EN the same way the design does.
module tb_rx_sync_fifo;

    localparam int DATA_BITS   = 8;
    localparam int FIFO_DEPTH  = 4;
    localparam int AFULL_LEVEL = 3;
    localparam int CNT_BITS    = $clog2(FIFO_DEPTH + 1);

    logic                 Clk;
    logic                 Rst;
    logic                 Wr_En;
    logic [DATA_BITS-1:0] Wr_Data;
    logic                 BIST_Mode;
    logic                 Rd_En;
    logic [DATA_BITS-1:0] Rd_Data;
    logic                 Rd_Valid;
    logic                 Clr_Err;
    logic [CNT_BITS-1:0]  Count;
    logic                 Empty;
    logic                 Full;
    logic                 Almost_Full;
    logic                 Overflow;
    logic                 Underflow;

    int checks = 0;
    int errors = 0;

    logic [DATA_BITS-1:0] model_q[$];
    logic                 exp_ovf;
    logic                 exp_udf;
    logic                 exp_valid;
    logic [DATA_BITS-1:0] exp_data;

    rx_sync_fifo #(
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .AFULL_LEVEL(AFULL_LEVEL)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Wr_En      (Wr_En),
        .Wr_Data    (Wr_Data),
        .BIST_Mode  (BIST_Mode),
        .Rd_En      (Rd_En),
        .Rd_Data    (Rd_Data),
        .Rd_Valid   (Rd_Valid),
        .Clr_Err    (Clr_Err),
        .Count      (Count),
        .Empty      (Empty),
        .Full       (Full),
        .Almost_Full(Almost_Full),
        .Overflow   (Overflow),
        .Underflow  (Underflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkAll();
        int n;
        n = model_q.size();
        checkOutput("count", 32'(Count), 32'(n));
        checkOutput("empty", 32'(Empty), 32'(n == 0));
        checkOutput("full", 32'(Full), 32'(n == FIFO_DEPTH));
        checkOutput("almost_full", 32'(Almost_Full), 32'(n >= AFULL_LEVEL));
        checkOutput("overflow", 32'(Overflow), 32'(exp_ovf));
        checkOutput("underflow", 32'(Underflow), 32'(exp_udf));
`ifdef FIFO_FWFT_EN
        checkOutput("rd_valid", 32'(Rd_Valid), 32'(n != 0));
        if (n != 0) begin
            checkOutput("rd_data", 32'(Rd_Data), 32'(model_q[0]));
        end
`else
        checkOutput("rd_valid", 32'(Rd_Valid), 32'(exp_valid));
        checkOutput("rd_data", 32'(Rd_Data), 32'(exp_data));
`endif
    endtask

    // Drive one cycle of inputs, advance the model by the FIFO rules, then check after the edge.
    task automatic applyStimulus(input logic rst, input logic we, input logic [DATA_BITS-1:0] wd,
                                 input logic bist, input logic re, input logic clr);
        logic was_empty;
        logic was_full;
        logic pop;
        logic push;
        Rst       = rst;
        Wr_En     = we;
        Wr_Data   = wd;
        BIST_Mode = bist;
        Rd_En     = re;
        Clr_Err   = clr;
        if (rst) begin
            model_q.delete();
            exp_ovf   = 1'b0;
            exp_udf   = 1'b0;
            exp_valid = 1'b0;
            exp_data  = '0;
        end else begin
            was_empty = (model_q.size() == 0);
            was_full  = (model_q.size() == FIFO_DEPTH);
            pop       = re && !was_empty;
            push      = we && !bist && (!was_full || pop);
            exp_valid = pop;
            if (pop) begin
                exp_data = model_q.pop_front();
            end
            if (push) begin
                model_q.push_back(wd);
            end
            if (we && !bist && was_full && !pop) begin
                exp_ovf = 1'b1;
            end else if (clr) begin
                exp_ovf = 1'b0;
            end
            if (re && was_empty) begin
                exp_udf = 1'b1;
            end else if (clr) begin
                exp_udf = 1'b0;
            end
        end
        @(posedge Clk);
        #1;
        checkAll();
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic doWrite(input logic [DATA_BITS-1:0] d);
        applyStimulus(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic doRead();
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        Rst = 1'b1; Wr_En = 1'b0; Wr_Data = '0; BIST_Mode = 1'b0; Rd_En = 1'b0; Clr_Err = 1'b0;
        exp_ovf = 1'b0; exp_udf = 1'b0; exp_valid = 1'b0; exp_data = '0;
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);

        // In-order basic traffic
        doWrite(8'h11); doWrite(8'h22); doWrite(8'h33);
        doRead(); doRead(); doRead();
        idle();

        // Fill past full, drain, clear the sticky error
        for (int i = 0; i < 5; i++) doWrite(8'hA0 + 8'(i));
        for (int i = 0; i < 4; i++) doRead();
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Wrap-around streaming with interleaved reads
        for (int i = 0; i < 10; i++) begin
            doWrite(8'(i));
            if (i >= 2) doRead();
        end
        doRead(); doRead();

        // Simultaneous read+write at full and at empty
        for (int i = 0; i < 4; i++) doWrite(8'hB0 + 8'(i));
        applyStimulus(1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) doRead();
        applyStimulus(1'b0, 1'b1, 8'h66, 1'b0, 1'b1, 1'b0);
        doRead();
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);

        // BIST blocks writes silently; reset mid-operation discards entries
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'hC0, 1'b1, 1'b0, 1'b0);
        doWrite(8'hD0); doWrite(8'hD1); doWrite(8'hD2);
        applyStimulus(1'b1, 1'b1, 8'hD3, 1'b0, 1'b1, 1'b0);
        idle();

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 99) < 1,
                          $urandom_range(0, 99) < 55,
                          DATA_BITS'($urandom),
                          $urandom_range(0, 99) < 5,
                          $urandom_range(0, 99) < 50,
                          $urandom_range(0, 99) < 5);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_sync_fifo.md
# rx_sync_fifo

Synchronous, parametrised receive FIFO between the UART receiver and the host-side read interface. It is a single-clock circular buffer that generalises the earlier event-clocked receive buffer. It adds wrap-around pointers, an occupancy count, a programmable almost-full threshold, sticky overflow/underflow error flags and a clean simultaneous read/write path. Writes come from the receiver's data-ready pulse; reads come from the host.

## Interface

Parameters:
- DATA_BITS, 8, width of each entry.
- FIFO_DEPTH, 16, number of entries; must be a power of two, ≥ 2.
- AFULL_LEVEL, 12, occupancy at or above which Almost_Full asserts; 1 ≤ AFULL_LEVEL ≤ FIFO_DEPTH.

Ports:
- Clk  input  1  single clock; all state changes on its rising edge.
- Rst  input  1  synchronous, active-high reset.
- Wr_En  input  1  write request; one entry per cycle while high (receiver Data_Rdy, one cycle wide).
- Wr_Data  input  DATA_BITS  entry to write.
- BIST_Mode  input  1  when high, writes are ignored; reads operate normally.
- Rd_En  input  1  read (pop) request.
- Rd_Data  output  DATA_BITS  read data.
- Rd_Valid  output  1  Rd_Data holds a valid popped entry (see Configuration).
- Clr_Err  input  1  clears Overflow and Underflow.
- Count  output  $clog2(FIFO_DEPTH+1)  current occupancy, 0..FIFO_DEPTH.
- Empty  output  1  Count == 0.
- Full  output  1  Count == FIFO_DEPTH.
- Almost_Full  output  1  Count ≥ AFULL_LEVEL.
- Overflow  output  1  sticky: a write was dropped.
- Underflow  output  1  sticky: a read was rejected.

## Operation

- Storage: FIFO_DEPTH × DATA_BITS array. Write and read pointers are $clog2(FIFO_DEPTH) bits wide and wrap from FIFO_DEPTH−1 to 0 by natural overflow. Full and empty are distinguished by Count only, never by pointer equality.
- Write accepted (wr_ok) = Wr_En & !BIST_Mode & (!Full | rd_ok). An accepted write stores Wr_Data at the write pointer and increments the write pointer.
- Read accepted (rd_ok) = Rd_En & !Empty. An accepted read increments the read pointer.
- Count next = Count + wr_ok − rd_ok.
- Full with simultaneous Rd_En and Wr_En: both are accepted, Count stays at FIFO_DEPTH, and the popped entry is the old head.
- Empty with simultaneous Rd_En and Wr_En: the write is accepted and the read is rejected (Underflow sets).
- A dropped write (Wr_En & !BIST_Mode & Full & !rd_ok) leaves contents and pointers unchanged and sets Overflow. Writes blocked by BIST_Mode never set Overflow.
- A rejected read (Rd_En & Empty) sets Underflow and leaves Rd_Data unchanged.
- Overflow and Underflow stay set until Rst or Clr_Err. If Clr_Err coincides with a new error event, the flag stays set (set wins).
- Empty, Full and Almost_Full are registered and are computed from next Count, so they are always consistent with Count in the same cycle.

## Timing

- Reset (Rst high at an edge): Count 0, Empty 1, Full 0, Almost_Full 0, Overflow 0, Underflow 0, Rd_Valid 0, Rd_Data 0, both pointers 0. Array contents are don't-care. Rst has priority over every other input. Reset mid-operation discards all stored entries.
- Write-to-flag latency: 1 cycle. The edge that accepts the write updates Count and the flags.
- Write-to-readable: an entry written at edge N can be accepted by a read at edge N+1.
- Throughput: one write and one read per cycle, sustained.
- Error flags assert on the edge of the offending request.

## Configuration

- FIFO_FWFT_EN defined (first-word-fall-through):
  - Rd_Data continuously shows the head entry whenever !Empty.
  - Rd_Valid = !Empty.
  - Rd_En acknowledges and pops the head; the next entry appears on the edge of the pop.
  - Zero-cycle read latency.
- FIFO_FWFT_EN not defined (standard):
  - Rd_Data is registered. On the edge that accepts a read it loads the head entry; otherwise it holds its value.
  - Rd_Valid is high for exactly the one cycle after each accepted read.
  - One-cycle read latency.

## Test plan

- Reset, write 0x11, 0x22, 0x33, read three times -> data out in order 0x11, 0x22, 0x33. Count goes 1, 2, 3, 2, 1, 0. Empty returns to 1. Standard mode: Rd_Valid one cycle after each Rd_En. FWFT mode: 0x11 visible before the first Rd_En.
- FIFO_DEPTH=4, AFULL_LEVEL=3: write 5 entries (0xA0..0xA4) -> Almost_Full at Count 3, Full at Count 4, 0xA4 dropped, Overflow=1. Reads return 0xA0..0xA3. Clr_Err clears Overflow.
- Wrap-around: FIFO_DEPTH=4, stream 10 entries 0x00..0x09 with interleaved reads, never exceeding Count 3 -> all 10 read back in order. Pointers wrap twice. No error flags.
- Simultaneous ops: at Full, Rd_En+Wr_En with 0x55 -> Count stays 4, old head popped, Overflow stays 0. At Empty, Rd_En+Wr_En with 0x66 -> Count 1, Underflow=1, next read returns 0x66.
- BIST_Mode=1 with Wr_En pulses -> Count stays 0, Overflow 0. Rst asserted with Count=3 -> next cycle Count 0, Empty 1, all flags and Rd_Valid 0.
